// File: rtl/cci_mpf_prim_fifo_skid_pkg.sv
// cci_mpf_prim_fifo_skid_pkg: state encoding and occupancy width shared by the skid FIFO.
package cci_mpf_prim_fifo_skid_pkg;
    localparam int OCC_BITS = 2;
    // Encoding doubles as the entry count, so occupancy is the state itself.
    typedef enum logic [OCC_BITS-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } t_skid_state;
endpackage

// File: rtl/cci_mpf_prim_sat_counter.sv
// cci_mpf_prim_sat_counter: saturating event counter that stops at all-ones.
module cci_mpf_prim_sat_counter #(
    parameter int N_BITS = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              inc,
    output logic [N_BITS-1:0] value
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) value <= '0;
        else if (inc && !(&value)) value <= value + N_BITS'(1);
    end
endmodule

// File: rtl/cci_mpf_prim_fifo_skid.sv
// cci_mpf_prim_fifo_skid: two-entry skid buffer that decouples a BRAM FIFO dequeue from downstream ready.
// Define CCI_MPF_PRIM_FIFO_SKID_STATS_EN to build the saturating stall counter.
module cci_mpf_prim_fifo_skid
    import cci_mpf_prim_fifo_skid_pkg::*;
#(
    parameter int N_DATA_BITS = 32,
    parameter int N_STAT_BITS = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_DATA_BITS-1:0] fifo_first,
    input  logic                   fifo_notEmpty,
    output logic                   fifo_deq,
    output logic [N_DATA_BITS-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OCC_BITS-1:0]    occupancy,
    output logic [N_STAT_BITS-1:0] stall_cycles
);
    t_skid_state state, state_nxt;
    logic [N_DATA_BITS-1:0] skid;
    logic load_main, load_skid, from_skid, deq_ok;

    // deq_ok is a registered copy of (state != FULL) that reset clears, keeping fifo_deq low in reset.
    assign fifo_deq  = fifo_notEmpty && deq_ok;
    assign out_valid = (state != EMPTY);
    assign occupancy = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= EMPTY;
            deq_ok <= 1'b0;
        end else begin
            state  <= state_nxt;
            deq_ok <= (state_nxt != FULL);
        end
    end

    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        from_skid = 1'b0;
        case (state)
            EMPTY: if (fifo_deq) begin
                state_nxt = ONE;
                load_main = 1'b1;
            end
            ONE: if (fifo_deq && out_ready) begin
                load_main = 1'b1;
            end else if (fifo_deq) begin
                state_nxt = FULL;
                load_skid = 1'b1;
            end else if (out_ready) begin
                state_nxt = EMPTY;
            end
            FULL: if (out_ready) begin
                state_nxt = ONE;
                from_skid = 1'b1;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (load_main) out_data <= fifo_first;
        else if (from_skid) out_data <= skid;
        if (load_skid) skid <= fifo_first;
    end

`ifdef CCI_MPF_PRIM_FIFO_SKID_STATS_EN
    cci_mpf_prim_sat_counter #(.N_BITS(N_STAT_BITS)) stall_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (out_valid && !out_ready),
        .value   (stall_cycles)
    );
`else
    assign stall_cycles = '0;
`endif
endmodule

// File: doc/cci_mpf_prim_fifo_skid.md
CCI_MPF_PRIM_FIFO_SKID -- requirements
Module: cci_mpf_prim_fifo_skid

Interface
REQ-001 The block SHALL have parameter N_DATA_BITS, default 32, payload width.
REQ-002 The block SHALL have parameter N_STAT_BITS, default 32, stall-counter width.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port fifo_first  input  N_DATA_BITS  head data of the upstream BRAM FIFO.
REQ-006 The block SHALL have port fifo_notEmpty  input  1  upstream FIFO head valid.
REQ-007 The block SHALL have port fifo_deq  output  1  dequeue strobe to the upstream FIFO.
REQ-008 The block SHALL have port out_data  output  N_DATA_BITS  downstream payload.
REQ-009 The block SHALL have port out_valid  output  1  out_data valid.
REQ-010 The block SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 The block SHALL have port occupancy  output  2  entries held (0..2).
REQ-012 The block SHALL have port stall_cycles  output  N_STAT_BITS  saturating stall count.

Function
REQ-013 The block SHALL hold at most two entries: main register (drives out_data) and skid register.
REQ-014 The state machine SHALL have states EMPTY, ONE and FULL; occupancy SHALL equal 0, 1 or 2 respectively.
REQ-015 fifo_deq SHALL be fifo_notEmpty AND (state != FULL), decoded from registered state only; out_ready SHALL NOT reach fifo_deq combinationally.
REQ-016 The transition EMPTY to ONE SHALL occur when fifo_deq=1, capturing fifo_first into main.
REQ-017 In ONE with fifo_deq=1 and out_ready=1, the block SHALL stay ONE and load fifo_first into main.
REQ-018 In ONE with fifo_deq=1 and out_ready=0, the block SHALL go to FULL and load fifo_first into skid.
REQ-019 In ONE with fifo_deq=0 and out_ready=1, the block SHALL go to EMPTY; otherwise it SHALL hold.
REQ-020 In FULL with out_ready=1, the block SHALL go to ONE and copy skid into main; otherwise it SHALL hold.
REQ-021 out_valid SHALL be (state != EMPTY), registered.
REQ-022 The block SHALL present data dequeued in cycle t on out_data in cycle t+1, and SHALL sustain one transfer per cycle with out_ready held high.
REQ-023 The block SHALL deliver entries in FIFO order with no loss or duplication under any out_ready pattern.
REQ-024 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-025 reset_n=0 SHALL asynchronously force state EMPTY, out_valid=0, occupancy=0, fifo_deq=0 and stall_cycles=0; out_data and skid SHALL be don't-care.
REQ-026 A reset asserted mid-transfer SHALL discard held entries; the first post-reset dequeue SHALL occur no earlier than the first clk edge after reset_n rises.

Configuration
REQ-027 With CCI_MPF_PRIM_FIFO_SKID_STATS_EN defined, stall_cycles SHALL increment by 1 each cycle with out_valid=1 and out_ready=0, saturating at all-ones.
REQ-028 Without CCI_MPF_PRIM_FIFO_SKID_STATS_EN, stall_cycles SHALL be constant 0 and no counter logic SHALL be instantiated; the port list SHALL be identical in both builds.

Structure
REQ-029 Package cci_mpf_prim_fifo_skid_pkg SHALL hold the t_skid_state enum (EMPTY, ONE, FULL) and the occupancy-width constant.
REQ-030 The stall counter SHALL be a sub-module cci_mpf_prim_sat_counter (parameter N_BITS; inputs clk, reset_n, inc; output value), instantiated only under the macro.

Verification
REQ-031 The bench SHALL cover streaming: 16 entries 0..15 with out_ready=1 -> fifo_deq high 16 consecutive cycles, out_data 0..15 back-to-back starting one cycle after the first deq.
REQ-032 The bench SHALL cover backpressure: out_ready=0 with FIFO holding 5 -> exactly 2 deqs, occupancy=2, fifo_deq=0, out_data=first entry stable.
REQ-033 The bench SHALL cover release from FULL: out_ready=1 -> entries emerge in order, occupancy 2,1,1 while upstream feeds, no gap.
REQ-034 The bench SHALL cover random out_ready at 50% for 10000 entries -> scoreboard order match, no drop or duplicate.
REQ-035 The bench SHALL cover async reset asserted between clk edges while FULL -> out_valid=0 and occupancy=0 before the next edge.
REQ-036 The bench SHALL cover STATS_EN with N_STAT_BITS=4 and 20 stall cycles -> stall_cycles=15; without the macro -> 0.
